// File: rtl/dffr_univ_pkg.sv
// rtl/dffr_univ_pkg.sv - shared mode encodings, slice selects and flop timing multipliers
package dffr_univ_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_UP   = 3'b100,
        MODE_DOWN = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_LOAD  = 3'd1,
        SEL_SHL   = 3'd2,
        SEL_SHR   = 3'd3,
        SEL_ARITH = 3'd4
    } slice_sel_e;

    // Library flop timing: rise/setup/hold scale by 2, fall/pulse width by 3.
    localparam int RISE_MULT = 2;
    localparam int FALL_MULT = 3;

endpackage

// File: rtl/univ_reg_bit.sv
// rtl/univ_reg_bit.sv - one bit slice: 5:1 next-state mux feeding an async-reset flop
module univ_reg_bit
    import dffr_univ_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  slice_sel_e sel,
    input  logic       load_bit,
    input  logic       shl_bit,
    input  logic       shr_bit,
    input  logic       arith_bit,
    output logic       q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_LOAD:  q_d = load_bit;
            SEL_SHL:   q_d = shl_bit;
            SEL_SHR:   q_d = shr_bit;
            SEL_ARITH: q_d = arith_bit;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dffr_univ_reg.sv
// rtl/dffr_univ_reg.sv - WIDTH-bit universal register; DFFR_UNIV_REG_SAT_EN selects saturating count
module dffr_univ_reg
    import dffr_univ_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               DELAY     = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             SerOut,
    output logic             Tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("dffr_univ_reg: WIDTH must be in 2..32");
    end

    mode_e            mode;
    slice_sel_e       sel;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] arith_val;
    logic             at_max;
    logic             at_min;
    logic             sat_hold;

    assign mode    = mode_e'(Mode);
    assign at_max  = &q;
    assign at_min  = ~|q;
    assign shl_val = {q[WIDTH-2:0], SerIn};
    assign shr_val = {SerIn, q[WIDTH-1:1]};

`ifdef DFFR_UNIV_REG_SAT_EN
    assign sat_hold = ((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_min);
`else
    assign sat_hold = 1'b0;
`endif

    // CLR shares the arithmetic path so each slice needs only a 5:1 mux.
    always_comb begin
        arith_val = '0;
        case (mode)
            MODE_UP:   arith_val = q + ONE;
            MODE_DOWN: arith_val = q - ONE;
            default:   arith_val = '0;
        endcase
    end

    always_comb begin
        sel = SEL_HOLD;
        if (En && !sat_hold) begin
            case (mode)
                MODE_LOAD:                     sel = SEL_LOAD;
                MODE_SHL:                      sel = SEL_SHL;
                MODE_SHR:                      sel = SEL_SHR;
                MODE_UP, MODE_DOWN, MODE_CLR:  sel = SEL_ARITH;
                default:                       sel = SEL_HOLD;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        univ_reg_bit #(
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk       (Clk),
            .rst       (Rst),
            .sel       (sel),
            .load_bit  (D[i]),
            .shl_bit   (shl_val[i]),
            .shr_bit   (shr_val[i]),
            .arith_bit (arith_val[i]),
            .q         (q[i])
        );
    end

    assign Q  = q;
    assign nQ = ~q;

    always_comb begin
        SerOut = 1'b0;
        Tc     = 1'b0;
        case (mode)
            MODE_SHL:  SerOut = q[WIDTH-1];
            MODE_SHR:  SerOut = q[0];
            MODE_UP:   Tc     = at_max;
            MODE_DOWN: Tc     = at_min;
            default: begin
                SerOut = 1'b0;
                Tc     = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    localparam real T_SETUP_HOLD = real'(RISE_MULT * DELAY);
    localparam real T_CLK_WIDTH  = real'(FALL_MULT * DELAY);
    localparam real T_RST_PULSE  = real'(10 * DELAY);

    realtime t_rise = -1000.0;
    realtime t_fall = -1000.0;
    realtime t_in   = -1000.0;
    realtime t_rst  = -1000.0;

    always @(posedge Clk) begin
        if (!Rst) begin
            if ($realtime - t_in < T_SETUP_HOLD) $error("dffr_univ_reg: setup violation");
            if ($realtime - t_fall < T_CLK_WIDTH) $error("dffr_univ_reg: Clk low too short");
        end
        t_rise <= $realtime;
    end

    always @(negedge Clk) begin
        if (!Rst && ($realtime - t_rise < T_CLK_WIDTH)) $error("dffr_univ_reg: Clk high too short");
        t_fall <= $realtime;
    end

    always @(D or SerIn or Mode or En) begin
        if (!Rst && ($realtime - t_rise < T_SETUP_HOLD)) $error("dffr_univ_reg: hold violation");
        t_in = $realtime;
    end

    always @(posedge Rst) t_rst <= $realtime;

    always @(negedge Rst) begin
        if ($realtime - t_rst < T_RST_PULSE) $error("dffr_univ_reg: Rst pulse too short");
    end
`endif

endmodule

// File: tb/tb_dffr_univ_reg.sv
// tb/tb_dffr_univ_reg.sv - scoreboard bench for dffr_univ_reg (WIDTH=8, RESET_VAL=8'hA5)
module tb_dffr_univ_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011,
                           M_UP = 3'b100, M_DOWN = 3'b101, M_CLR = 3'b110, M_RSVD = 3'b111;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       En;
    logic [2:0] Mode;
    logic [7:0] D;
    logic       SerIn;
    logic [7:0] Q;
    logic [7:0] nQ;
    logic       SerOut;
    logic       Tc;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_q;
    logic [7:0] exp_q;
    logic       exp_so;
    logic       exp_tc;
    logic [7:0] sb[$];

    always #5 Clk = ~Clk;

    dffr_univ_reg #(.WIDTH(W), .RESET_VAL(RV), .DELAY(1)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .D(D), .SerIn(SerIn),
        .Q(Q), .nQ(nQ), .SerOut(SerOut), .Tc(Tc)
    );

    function automatic logic [7:0] model_next(input logic [7:0] q, input logic [2:0] m,
                                              input logic [7:0] d, input logic si, input logic en);
        if (!en) return q;
        case (m)
            M_LOAD: return d;
            M_SHL:  return {q[6:0], si};
            M_SHR:  return {si, q[7:1]};
            M_UP: begin
`ifdef DFFR_UNIV_REG_SAT_EN
                if (q == 8'hFF) return q;
`endif
                return q + 8'd1;
            end
            M_DOWN: begin
`ifdef DFFR_UNIV_REG_SAT_EN
                if (q == 8'h00) return q;
`endif
                return q - 8'd1;
            end
            M_CLR:  return 8'h00;
            default: return q;
        endcase
    endfunction

    task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic si, input logic en);
        Mode  = m;
        D     = d;
        SerIn = si;
        En    = en;
        exp_so = (m == M_SHL) ? m_q[7] : (m == M_SHR) ? m_q[0] : 1'b0;
        exp_tc = (m == M_UP) ? (m_q == 8'hFF) : (m == M_DOWN) ? (m_q == 8'h00) : 1'b0;
        m_q = model_next(m_q, m, d, si, en);
        sb.push_back(m_q);
    endtask

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Rst = 1'b1; En = 1'b1; Mode = M_UP; D = 8'h00; SerIn = 1'b0;
        #3;
        n_checks++;
        if (Q !== RV || nQ !== ~RV) begin
            n_fail++; $display("FAIL reset_async: Q=%h nQ=%h expected Q=%h nQ=%h", Q, nQ, RV, ~RV);
        end
        @(negedge Clk);
        n_checks++;
        if (Q !== RV) begin
            n_fail++; $display("FAIL reset_edge_ignored: Q=%h expected %h", Q, RV);
        end
        Rst = 1'b0;
        m_q = RV;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            drive(M_HOLD, 8'hFF, 1'b1, 1'b1);
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q || nQ !== ~exp_q) begin
                n_fail++; $display("FAIL reset_hold[%0d]: Q=%h nQ=%h expected Q=%h", i, Q, nQ, exp_q);
            end
        end
    endtask

    task automatic test_load_shift;
        drive(M_LOAD, 8'h81, 1'b0, 1'b1);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q || exp_q !== 8'h81) begin
            n_fail++; $display("FAIL load: Q=%h expected %h", Q, exp_q);
        end
        drive(M_SHL, 8'h00, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (SerOut !== exp_so || Tc !== exp_tc) begin
            n_fail++; $display("FAIL shl_flags: SerOut=%b Tc=%b expected %b %b", SerOut, Tc, exp_so, exp_tc);
        end
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q || nQ !== ~exp_q) begin
            n_fail++; $display("FAIL shl: Q=%h nQ=%h expected Q=%h", Q, nQ, exp_q);
        end
        drive(M_SHR, 8'h00, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (SerOut !== exp_so) begin
            n_fail++; $display("FAIL shr_serout: SerOut=%b expected %b", SerOut, exp_so);
        end
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++; $display("FAIL shr: Q=%h expected %h", Q, exp_q);
        end
    endtask

    task automatic test_count;
        logic [2:0] seq_m[5];
        seq_m = '{M_LOAD, M_UP, M_UP, M_DOWN, M_DOWN};
        for (int i = 0; i < 5; i++) begin
            drive(seq_m[i], 8'hFE, 1'b0, 1'b1);
            #1;
            n_checks++;
            if (Tc !== exp_tc || SerOut !== 1'b0) begin
                n_fail++; $display("FAIL count_flags[%0d]: Tc=%b SerOut=%b expected Tc=%b", i, Tc, SerOut, exp_tc);
            end
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q || nQ !== ~exp_q) begin
                n_fail++; $display("FAIL count[%0d]: Q=%h nQ=%h expected Q=%h", i, Q, nQ, exp_q);
            end
        end
    endtask

    task automatic test_saturation;
        logic [2:0] seq_m[8];
        logic [7:0] seq_d[8];
        seq_m = '{M_LOAD, M_UP, M_UP, M_UP, M_UP, M_LOAD, M_DOWN, M_DOWN};
        seq_d = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            drive(seq_m[i], seq_d[i], 1'b0, 1'b1);
            #1;
            n_checks++;
            if (Tc !== exp_tc) begin
                n_fail++; $display("FAIL sat_tc[%0d]: Tc=%b expected %b", i, Tc, exp_tc);
            end
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++; $display("FAIL sat[%0d]: Q=%h expected %h", i, Q, exp_q);
            end
        end
    endtask

    task automatic test_enable_clear_reserved;
        drive(M_LOAD, 8'hFF, 1'b0, 1'b1);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(M_UP, 8'h00, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (Tc !== exp_tc) begin
                n_fail++; $display("FAIL en0_tc[%0d]: Tc=%b expected %b", i, Tc, exp_tc);
            end
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++; $display("FAIL en0_hold[%0d]: Q=%h expected %h", i, Q, exp_q);
            end
        end
        drive(M_CLR, 8'h77, 1'b1, 1'b1);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q || nQ !== ~exp_q) begin
            n_fail++; $display("FAIL clr: Q=%h nQ=%h expected Q=%h", Q, nQ, exp_q);
        end
        drive(M_LOAD, 8'h5A, 1'b0, 1'b1);
        tick();
        void'(sb.pop_front());
        drive(M_RSVD, 8'h00, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (SerOut !== 1'b0 || Tc !== 1'b0) begin
            n_fail++; $display("FAIL rsvd_flags: SerOut=%b Tc=%b expected 0 0", SerOut, Tc);
        end
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++; $display("FAIL rsvd_hold: Q=%h expected %h", Q, exp_q);
        end
    endtask

    task automatic test_async_reset;
        drive(M_LOAD, 8'h10, 1'b0, 1'b1);
        tick();
        void'(sb.pop_front());
        drive(M_UP, 8'h00, 1'b0, 1'b1);
        tick();
        exp_q = sb.pop_front();
        n_checks++;
        if (Q !== exp_q) begin
            n_fail++; $display("FAIL pre_rst_count: Q=%h expected %h", Q, exp_q);
        end
        #1 Rst = 1'b1;
        m_q = RV;
        sb.delete();
        #2;
        n_checks++;
        if (Q !== RV || nQ !== ~RV) begin
            n_fail++; $display("FAIL mid_rst: Q=%h nQ=%h expected Q=%h", Q, nQ, RV);
        end
        #8 Rst = 1'b0;
        n_checks++;
        if (Q !== RV) begin
            n_fail++; $display("FAIL rst_held: Q=%h expected %h", Q, RV);
        end
        for (int i = 0; i < 2; i++) begin
            drive(M_UP, 8'h00, 1'b0, 1'b1);
            tick();
            exp_q = sb.pop_front();
            n_checks++;
            if (Q !== exp_q) begin
                n_fail++; $display("FAIL resume[%0d]: Q=%h expected %h", i, Q, exp_q);
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_shift();
        test_count();
        test_saturation();
        test_enable_clear_reserved();
        test_async_reset();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
